tdc_fifo_reader: RTL and testbench

- Parametrised multi-channel reader for the TDC result FIFOs; successor to the single-shot, single-FIFO TDC read block.
- Arbitrates round-robin among NUM_CH FIFOs by their empty flags and generates CSN/RDN/address strobes with programmable setup and strobe widths.
- Single-word mode or burst-drain mode; delivers words, tagged with channel index, over a valid/ready stream toward the SDK-side capture logic.

---
 rtl/tdc_fifo_reader.sv | 271 +++++++++++++++++++++++++++
 tb/tb_tdc_fifo_reader.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_fifo_reader.sv
// Round-robin reader for NUM_CH TDC result FIFOs: CSN/RDN strobe sequencing and a
// channel-tagged valid/ready output stream. Define TDC_RD_CNT_EN for the rd_count port.
module tdc_fifo_reader #(
    parameter int DATA_W     = 28,
    parameter int ADDR_W     = 4,
    parameter int NUM_CH     = 2,
    parameter int SETUP_CYC  = 1,
    parameter int RD_LOW_CYC = 2,
    parameter int MAX_BURST  = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH-1:0]        ef,
    input  logic [DATA_W-1:0]        tdc_data,
    output logic [ADDR_W-1:0]        tdc_addr,
    output logic                     CSN,
    output logic                     RDN,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
`ifdef TDC_RD_CNT_EN
    input  logic                     rd_count_clr,
    output logic [31:0]              rd_count,
`endif
    output logic                     empty_err
);

    localparam int RECOV_CYC = 3;
    localparam int PH_MAX0   = (SETUP_CYC > RD_LOW_CYC) ? SETUP_CYC : RD_LOW_CYC;
    localparam int PH_MAX    = (PH_MAX0 > RECOV_CYC) ? PH_MAX0 : RECOV_CYC;
    localparam int PH_W      = $clog2(PH_MAX);
    localparam int BCNT_W    = $clog2(MAX_BURST + 1);

    localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]   STROBE_LAST = PH_W'(RD_LOW_CYC - 1);
    localparam logic [PH_W-1:0]   RECOV_LAST = PH_W'(RECOV_CYC - 1);
    localparam logic [BCNT_W-1:0] BURST_LIM  = BCNT_W'(MAX_BURST);
    localparam logic [CH_W:0]     CH_LIM     = (CH_W + 1)'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_STROBE,
        S_RECOV,
        S_PRESENT
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    // NOTE: sequential state is always written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    logic [NUM_CH-1:0] ef_s1, ef_s2;
    logic              st_s1, st_s2, st_s3;
    logic              start_edge;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ef_s1 <= '1;
            ef_s2 <= '1;
            st_s1 <= 1'b0;
            st_s2 <= 1'b0;
            st_s3 <= 1'b0;
        end else begin
            ef_s1 <= ef;
            ef_s2 <= ef_s1;
            st_s1 <= start;
            st_s2 <= st_s1;
            st_s3 <= st_s2;
        end
    end

    assign start_edge = st_s2 & ~st_s3;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic                mode_q;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_inc;
    logic [CH_W-1:0]     ch_q, ptr_q, pick;
    logic                pick_found;
    logic [ADDR_W-1:0]   addr_arr [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            addr_arr[i] = ch_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Round-robin search starting one past the channel served last.
    always_comb begin
        logic [CH_W:0] sum;
        logic [CH_W-1:0] idx;
        pick_found = 1'b0;
        pick       = '0;
        sum        = '0;
        idx        = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            sum = {1'b0, ptr_q} + (CH_W + 1)'(k);
            if (sum >= CH_LIM) begin
                sum = sum - CH_LIM;
            end
            idx = sum[CH_W-1:0];
            if (!pick_found && !ef_s2[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    assign bcnt_inc = bcnt_q + 1'b1;

    logic arm, grant, capture, accept, present_entry;
    logic done_d, err_d, csn_d, rdn_d, busy_d;

    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        arm     = 1'b0;
        grant   = 1'b0;
        capture = 1'b0;
        accept  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_ARB;
                    arm     = 1'b1;
                end
            end
            S_ARB: begin
                ph_d = '0;
                if (pick_found) begin
                    state_d = S_SETUP;
                    grant   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_SETUP: begin
                if (ph_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_STROBE: begin
                if (ph_q == STROBE_LAST) begin
                    state_d = S_RECOV;
                    ph_d    = '0;
                    capture = 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_RECOV: begin
                if (ph_q == RECOV_LAST) begin
                    state_d = S_PRESENT;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_PRESENT: begin
                if (out_valid && out_ready) begin
                    accept = 1'b1;
                    if (mode_q && (bcnt_inc < BURST_LIM) && !(&ef_s2)) begin
                        state_d = S_ARB;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        present_entry = (state_q == S_RECOV) && (state_d == S_PRESENT);
        // Strobes are decoded from the next state and registered, so the TDC sees glitch-free pins.
        csn_d  = !((state_d == S_SETUP) || (state_d == S_STROBE) ||
                   ((state_d == S_RECOV) && (ph_d == '0)));
        rdn_d  = !(state_d == S_STROBE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            mode_q    <= 1'b0;
            bcnt_q    <= '0;
            ch_q      <= '0;
            ptr_q     <= '0;
            tdc_addr  <= '0;
            CSN       <= 1'b1;
            RDN       <= 1'b1;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            empty_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            CSN       <= csn_d;
            RDN       <= rdn_d;
            busy      <= busy_d;
            done      <= done_d;
            empty_err <= err_d;
            out_valid <= (state_d == S_PRESENT);
            if (arm) begin
                mode_q <= mode;
                bcnt_q <= '0;
            end
            if (grant) begin
                ch_q     <= pick;
                tdc_addr <= addr_arr[pick];
            end
            if (capture) begin
                out_data <= tdc_data;
            end
            if (present_entry) begin
                out_ch <= ch_q;
                ptr_q  <= ch_q;
            end
            if (accept) begin
                bcnt_q <= bcnt_inc;
            end
        end
    end

`ifdef TDC_RD_CNT_EN
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rd_count <= '0;
        end else if (rd_count_clr) begin
            rd_count <= '0;
        end else if (accept) begin
            rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_fifo_reader.sv
// Scoreboard bench for tdc_fifo_reader: TDC FIFO emulation, queue-based reference model
// of round-robin draining, and a decoupled monitor that checks pins and the output stream.
module tb_tdc_fifo_reader;

    localparam int DATA_W     = 28;
    localparam int ADDR_W     = 4;
    localparam int NUM_CH     = 2;
    localparam int SETUP_CYC  = 1;
    localparam int RD_LOW_CYC = 2;
    localparam int MAX_BURST  = 6;
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CSN_LOW    = SETUP_CYC + RD_LOW_CYC + 1;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     start = 1'b0;
    logic                     mode = 1'b0;
    logic [NUM_CH*ADDR_W-1:0] ch_addr = {4'h9, 4'h8};
    logic [NUM_CH-1:0]        ef = '1;
    logic [DATA_W-1:0]        tdc_data = '0;
    logic                     out_ready = 1'b1;
    logic [ADDR_W-1:0]        tdc_addr;
    logic                     CSN, RDN;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid, busy, done, empty_err;
`ifdef TDC_RD_CNT_EN
    logic                     rd_count_clr = 1'b0;
    logic [31:0]              rd_count;
`endif

    tdc_fifo_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
        .SETUP_CYC(SETUP_CYC), .RD_LOW_CYC(RD_LOW_CYC), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .ch_addr(ch_addr), .ef(ef), .tdc_data(tdc_data), .tdc_addr(tdc_addr),
        .CSN(CSN), .RDN(RDN), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
`ifdef TDC_RD_CNT_EN
        .rd_count_clr(rd_count_clr), .rd_count(rd_count),
`endif
        .empty_err(empty_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef struct {
        bit err;
        int words;
    } end_t;

    logic [DATA_W-1:0] tdc_q [NUM_CH][$];
    word_t             exp_word [$];
    end_t              exp_end [$];
    logic [CH_W-1:0]   acc_ch_log [$];
    int n_checks = 0, n_err = 0;
    int mdl_ptr = 0, csn_falls = 0, acc_since_rst = 0, ready_ctl = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int addr_to_ch(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_addr[i*ADDR_W +: ADDR_W] == a) return i;
        end
        return -1;
    endfunction

    task automatic refresh_ef();
        for (int i = 0; i < NUM_CH; i++) ef[i] = (tdc_q[i].size() == 0);
    endtask

    task automatic fill(input int ch, input int n);
        for (int i = 0; i < n; i++) tdc_q[ch].push_back(DATA_W'($urandom));
        refresh_ef();
    endtask

    task automatic flush_fifos();
        for (int i = 0; i < NUM_CH; i++) tdc_q[i].delete();
        refresh_ef();
    endtask

    // Expected outcome of one armed transaction, from the FIFO contents at arm time.
    task automatic model_txn(input bit m);
        int    taken [NUM_CH];
        int    words;
        bit    more;
        word_t w;
        end_t  e;
        words = 0;
        more  = 1'b1;
        for (int i = 0; i < NUM_CH; i++) taken[i] = 0;
        while (more) begin
            int c;
            c = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                int idx;
                idx = (mdl_ptr + k) % NUM_CH;
                if (c < 0 && tdc_q[idx].size() > taken[idx]) c = idx;
            end
            if (c < 0) begin
                more = 1'b0;
            end else begin
                w.ch   = CH_W'(c);
                w.data = tdc_q[c][taken[c]];
                exp_word.push_back(w);
                taken[c]++;
                mdl_ptr = c;
                words++;
                more = 1'b0;
                if (m && words < MAX_BURST) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (tdc_q[i].size() > taken[i]) more = 1'b1;
                    end
                end
            end
        end
        e.err   = (words == 0);
        e.words = words;
        exp_end.push_back(e);
    endtask

    task automatic issue_start(input bit m);
        model_txn(m);
        @(posedge clk); #1;
        mode  = m;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int c;
        c = 0;
        while (exp_end.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("txn_complete", exp_end.size() == 0, 1'b1);
        if (exp_end.size() != 0) begin
            exp_word.delete();
            exp_end.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run(input bit m);
        issue_start(m);
        wait_end(2000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, c, last;
        fork
            begin : tdc_emulation
                int rd_ch;
                bit rd_active;
                rd_active = 1'b0;
                rd_ch     = -1;
                forever begin
                    @(RDN);
                    if (RDN === 1'b0) begin
                        rd_ch     = addr_to_ch(tdc_addr);
                        rd_active = 1'b1;
                        if (rd_ch >= 0 && tdc_q[rd_ch].size() > 0) tdc_data = tdc_q[rd_ch][0];
                        else tdc_data = 28'hBADBEEF;
                    end else if (RDN === 1'b1 && rd_active) begin
                        rd_active = 1'b0;
                        if (rd_ch >= 0 && tdc_q[rd_ch].size() > 0) void'(tdc_q[rd_ch].pop_front());
                        tdc_data = 28'h5A5A5A5;
                        refresh_ef();
                    end
                end
            end
            begin : monitor
                int              csn_run, rdn_run, txn_words;
                bit              prev_hold, prev_csn, prev_rdn;
                logic [DATA_W-1:0] prev_data;
                logic [CH_W-1:0] prev_ch;
                word_t           w;
                end_t            e;
                csn_run = 0; rdn_run = 0; txn_words = 0;
                prev_hold = 1'b0; prev_csn = 1'b1; prev_rdn = 1'b1;
                prev_data = '0; prev_ch = '0;
                forever begin
                    @(negedge clk);
                    if (!reset_n) begin
                        csn_run = 0; rdn_run = 0; txn_words = 0; acc_since_rst = 0;
                        prev_hold = 1'b0; prev_csn = 1'b1; prev_rdn = 1'b1;
                        continue;
                    end
                    if (prev_hold) begin
                        check("hold_valid", out_valid, 1'b1);
                        check("hold_data", out_data, prev_data);
                        check("hold_ch", out_ch, prev_ch);
                    end
                    prev_hold = out_valid && !out_ready;
                    prev_data = out_data;
                    prev_ch   = out_ch;
                    if (out_valid) check("csn_high_while_valid", CSN, 1'b1);
                    if (!RDN) check("rdn_within_csn", CSN, 1'b0);
                    if (!CSN && prev_csn) csn_falls++;
                    if (!CSN) csn_run++;
                    else if (!prev_csn) begin
                        check("csn_low_cycles", csn_run, CSN_LOW);
                        csn_run = 0;
                    end
                    if (!RDN) rdn_run++;
                    else if (!prev_rdn) begin
                        check("rdn_low_cycles", rdn_run, RD_LOW_CYC);
                        rdn_run = 0;
                    end
                    prev_csn = CSN;
                    prev_rdn = RDN;
                    if (out_valid && out_ready) begin
                        check("word_expected", exp_word.size() != 0, 1'b1);
                        if (exp_word.size() != 0) begin
                            w = exp_word.pop_front();
                            check("out_data", out_data, w.data);
                            check("out_ch", out_ch, w.ch);
                        end
                        acc_ch_log.push_back(out_ch);
                        txn_words++;
                        acc_since_rst++;
                    end
                    if (done || empty_err) begin
                        check("done_with_err", done, 1'b1);
                        check("busy_low_at_done", busy, 1'b0);
                        check("done_expected", exp_end.size() != 0, 1'b1);
                        if (exp_end.size() != 0) begin
                            e = exp_end.pop_front();
                            check("empty_err", empty_err, e.err);
                            check("txn_words", txn_words, e.words);
                        end
                        txn_words = 0;
                    end
                end
            end
            begin : ready_driver
                forever begin
                    @(posedge clk); #1;
                    case (ready_ctl)
                        0:       out_ready = 1'b1;
                        1:       out_ready = 1'($urandom_range(0, 1));
                        default: out_ready = 1'b0;
                    endcase
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_csn", CSN, 1'b1);
        check("rst_rdn", RDN, 1'b1);
        check("rst_tdc_addr", tdc_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_empty_err", empty_err, 1'b0);

        // Single read from ch0 only
        flush_fifos();
        tdc_q[0].push_back(28'h0ABCDEF);
        refresh_ef();
        f0 = csn_falls;
        run(1'b0);
        check("single_tdc_addr", tdc_addr, 4'h8);
        check("single_busy_after", busy, 1'b0);
        check("single_one_strobe", csn_falls - f0, 1);

        // All FIFOs empty
        flush_fifos();
        f0 = csn_falls;
        run(1'b0);
        check("empty_no_strobe", csn_falls - f0, 0);

        // One word from ch1 leaves the pointer at ch1
        fill(1, 1);
        run(1'b0);
        check("ch1_tdc_addr", tdc_addr, 4'h9);

        // Drain 3 words on ch0 and 2 on ch1
        flush_fifos();
        fill(0, 3);
        fill(1, 2);
        acc_ch_log.delete();
        run(1'b1);
        check("drain_count", acc_ch_log.size(), 5);
        for (int i = 0; i < acc_ch_log.size(); i++) check("drain_ch_order", acc_ch_log[i], i % 2);

        // Burst limit with FIFOs that never run dry, then round-robin continuation
        flush_fifos();
        fill(0, 20);
        fill(1, 20);
        acc_ch_log.delete();
        run(1'b1);
        check("burst_limit", acc_ch_log.size(), MAX_BURST);
        last = (acc_ch_log.size() > 0) ? int'(acc_ch_log[$]) : 0;
        acc_ch_log.delete();
        run(1'b1);
        check("burst_limit_2", acc_ch_log.size(), MAX_BURST);
        if (acc_ch_log.size() > 0) check("rr_continue", acc_ch_log[0], (last + 1) % NUM_CH);

        // Downstream stall for 10 cycles, with a start edge while busy
        flush_fifos();
        fill(0, 1);
        fill(1, 1);
        ready_ctl = 2;
        issue_start(1'b0);
        c = 0;
        while (!out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("stall_valid_seen", out_valid, 1'b1);
        f0 = csn_falls;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stall_no_new_csn", csn_falls - f0, 0);
        check("stall_still_valid", out_valid, 1'b1);
        ready_ctl = 0;
        wait_end(200);
        repeat (30) @(posedge clk);
        #1;
        check("busy_start_ignored", busy, 1'b0);

        // Randomised single and drain transactions with random backpressure
        flush_fifos();
        ready_ctl = 1;
        for (int t = 0; t < 25; t++) begin
            for (int ch = 0; ch < NUM_CH; ch++) fill(ch, $urandom_range(0, 3));
            run(1'($urandom_range(0, 1)));
        end
        ready_ctl = 0;

        // Reset pulse in the middle of a strobe
        flush_fifos();
        fill(0, 2);
        fill(1, 2);
        issue_start(1'b0);
        c = 0;
        while (RDN !== 1'b0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("strobe_reached", RDN, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_csn", CSN, 1'b1);
        check("async_rst_rdn", RDN, 1'b1);
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        exp_word.delete();
        exp_end.delete();
        mdl_ptr = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        f0 = csn_falls;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_idle_busy", busy, 1'b0);
        check("post_rst_no_csn", csn_falls - f0, 0);
        check("post_rst_valid", out_valid, 1'b0);
        run(1'b0);
        run(1'b1);

`ifdef TDC_RD_CNT_EN
        check("rd_count", rd_count, acc_since_rst);
        @(posedge clk); #1 rd_count_clr = 1'b1;
        @(posedge clk); #1 rd_count_clr = 1'b0;
        check("rd_count_clr", rd_count, 0);
`endif

        check("no_pending_words", exp_word.size(), 0);
        check("no_pending_ends", exp_end.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
